acc_reg_bank: RTL

Parametrised successor to the processor's accumulator/register cache. It provides a 2^PW-entry, DW-bit register array with entry 0 acting as the accumulator, two combinational read ports, and an immediate-select path on port B. A sequential clear engine zeroes the array after reset or on request. The block sits between the decode/control unit and the ALU, feeding accumulator and operand values.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/acc_reg_bank_if.sv | 37 +++
 rtl/regfile_clr_fsm.sv | 54 +++++
 rtl/acc_reg_bank.sv | 113 +++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the accumulator/register bank and its clear engine.
package regfile_pkg;

    localparam int DEF_DW   = 8;
    localparam int DEF_PW   = 4;
    localparam int DEF_IW   = 5;
    localparam int ACC_ADDR = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/acc_reg_bank_if.sv
// Decode/control-side bus of the accumulator/register bank: writes, reads, immediate and clear control.
interface acc_reg_bank_if
    import regfile_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int PW = DEF_PW,
    parameter int IW = DEF_IW
);

    logic          clr_req;
    logic          busy;
    logic          acc_we;
    logic          reg_we;
    logic [PW-1:0] waddr;
    logic [DW-1:0] dat_in;
    logic [PW-1:0] raddr_a;
    logic [PW-1:0] raddr_b;
    logic          imm_sel;
    logic [IW-1:0] imm;
    logic [DW-1:0] acc_out;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic          wr_err;

    modport master (
        output clr_req, acc_we, reg_we, waddr, dat_in,
               raddr_a, raddr_b, imm_sel, imm,
        input  busy, acc_out, rd_a, rd_b, wr_err
    );

    modport slave (
        input  clr_req, acc_we, reg_we, waddr, dat_in,
               raddr_a, raddr_b, imm_sel, imm,
        output busy, acc_out, rd_a, rd_b, wr_err
    );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear sweep engine: walks every entry once after reset or on request, zeroing it.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [PW-1:0] clr_addr
);

    localparam logic [PW-1:0] LAST_PTR = '1;

    clr_state_e    state;
    logic [PW-1:0] clr_ptr;

    // busy drops on the same edge that clears the last entry; the pointer wraps back to 0 by itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST_PTR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

    assign clr_we   = (state == CLEAR);
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/acc_reg_bank.sv
// Accumulator/register bank: entry 0 is the accumulator, two read ports, immediate select on port B.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module acc_reg_bank
    import regfile_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int PW = DEF_PW,
    parameter int IW = DEF_IW
) (
    input  logic          clk,
    input  logic          rst_n,
    acc_reg_bank_if.slave bus
);

    localparam int            DEPTH   = 1 << PW;
    localparam logic [PW-1:0] ACC_IDX = PW'(ACC_ADDR);

    logic [DW-1:0] core [DEPTH];

    logic          busy;
    logic          clr_we;
    logic [PW-1:0] clr_addr;

    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] acc_val;
    logic [DW-1:0] a_val;
    logic [DW-1:0] b_val;
    logic          wr_err;

    regfile_clr_fsm #(
        .PW(PW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The sweep owns the write port while it runs; host writes are simply not selected then
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
        end else if (bus.acc_we) begin
            wr_en   = 1'b1;
            wr_addr = ACC_IDX;
            wr_data = bus.dat_in;
        end else if (bus.reg_we) begin
            wr_en   = 1'b1;
            wr_addr = bus.waddr;
            wr_data = bus.dat_in;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            core[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= busy & (bus.acc_we | bus.reg_we);
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic          host_we;
    logic [PW-1:0] host_addr;

    assign host_we   = !busy && (bus.acc_we || bus.reg_we);
    assign host_addr = bus.acc_we ? ACC_IDX : bus.waddr;

    always_comb begin
        acc_val = core[ACC_IDX];
        a_val   = core[bus.raddr_a];
        b_val   = core[bus.raddr_b];
        if (host_we && host_addr == ACC_IDX) begin
            acc_val = bus.dat_in;
        end
        if (host_we && host_addr == bus.raddr_a) begin
            a_val = bus.dat_in;
        end
        if (host_we && host_addr == bus.raddr_b) begin
            b_val = bus.dat_in;
        end
    end
`else
    always_comb begin
        acc_val = core[ACC_IDX];
        a_val   = core[bus.raddr_a];
        b_val   = core[bus.raddr_b];
    end
`endif

    // Array contents are undefined until the sweep finishes, so register reads are masked while busy
    assign bus.acc_out = busy ? '0 : acc_val;
    assign bus.rd_a    = busy ? '0 : a_val;
    assign bus.rd_b    = bus.imm_sel ? DW'(bus.imm) : (busy ? '0 : b_val);
    assign bus.busy    = busy;
    assign bus.wr_err  = wr_err;

endmodule
